// File: rtl/sram_1rw1r_pipe.sv
// Purpose : 1RW + 1R single-clock SRAM with byte-lane write mask and read-valid strobes.
// Latency : READ_LATENCY (1 or 2) clk0 edges from an accepted read to dout/valid.
// Backpr. : none; ready=0 during reset/clear, and requests presented then are dropped.
//
// Ports
//   clk0, rst0           single clock, synchronous active-high reset
//   ready                high once the array is usable (RUN state)
//   csb0/web0/wmask0     port 0 chip select / write enable (active low), lane write mask
//   addr0/din0/dout0     port 0 address, write data, read data
//   dout0_valid          one-cycle pulse per port-0 read result
//   csb1/addr1/dout1     port 1 read-only chip select (active low), address, read data
//   dout1_valid          one-cycle pulse per port-1 read result
//   collision            pulses with dout1_valid when that read met a same-address write
module sram_1rw1r_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 9,
  parameter int WMASK_WIDTH    = 8,
  parameter int READ_LATENCY   = 1,
  parameter int COLLISION_MODE = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_WMASKS    = DATA_WIDTH / WMASK_WIDTH,
  localparam int RAM_DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision
);

  localparam logic [1:0] ST_RESET = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  // ---------------------------------------------------------------------------
  // Init sequencer: RESET -> (CLEAR ->) RUN. The clear walks every address once;
  // leaving on the all-ones address gives exactly RAM_DEPTH clear edges.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state    <= ST_RESET;
      clr_addr <= '0;
    end else begin
      case (state)
        ST_RESET: begin
          clr_addr <= '0;
          state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_WIDTH'(1);
          if (&clr_addr) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RESET;
        end
      endcase
    end
  end

  assign ready = (state == ST_RUN);

  // ---------------------------------------------------------------------------
  // Request qualification. A reset edge never commits a request, even if the
  // sequencer was in RUN just before it.
  // ---------------------------------------------------------------------------
  logic req_ok;
  logic wr0;
  logic rd0;
  logic rd1;
  logic col;
  logic clr_we;

  assign req_ok = ready & ~rst0;
  // An all-zero mask is a no-op write: it changes nothing and cannot collide.
  assign wr0    = req_ok & ~csb0 & ~web0 & (|wmask0);
  assign rd0    = req_ok & ~csb0 &  web0;
  assign rd1    = req_ok & ~csb1;
  assign col    = wr0 & rd1 & (addr0 == addr1);
  assign clr_we = ~rst0 & (state == ST_CLEAR);

  // ---------------------------------------------------------------------------
  // Storage. Clear and user writes are mutually exclusive by state, so a single
  // write port is enough.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) begin
          mem[addr0][i*WMASK_WIDTH +: WMASK_WIDTH] <= din0[i*WMASK_WIDTH +: WMASK_WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read data. Array reads see the pre-edge contents (read-before-write), which
  // is the MODE 0 collision answer; MODE 1 overlays the lanes being written.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rdata0;
  logic [DATA_WIDTH-1:0] rdata1_old;
  logic [DATA_WIDTH-1:0] rdata1_merged;
  logic [DATA_WIDTH-1:0] rdata1;

  assign rdata0     = mem[addr0];
  assign rdata1_old = mem[addr1];

  always_comb begin
    rdata1_merged = rdata1_old;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0[i]) begin
        rdata1_merged[i*WMASK_WIDTH +: WMASK_WIDTH] = din0[i*WMASK_WIDTH +: WMASK_WIDTH];
      end
    end
  end

  assign rdata1 = ((COLLISION_MODE != 0) && col) ? rdata1_merged : rdata1_old;

  // ---------------------------------------------------------------------------
  // First output stage. Data registers only load on a read so the outputs hold
  // the last result between pulses.
  // ---------------------------------------------------------------------------
  logic                  s1_vld0;
  logic                  s1_vld1;
  logic                  s1_col;
  logic [DATA_WIDTH-1:0] s1_dat0;
  logic [DATA_WIDTH-1:0] s1_dat1;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      s1_vld0 <= 1'b0;
      s1_vld1 <= 1'b0;
      s1_col  <= 1'b0;
      s1_dat0 <= '0;
      s1_dat1 <= '0;
    end else begin
      s1_vld0 <= rd0;
      s1_vld1 <= rd1;
      s1_col  <= col;
      if (rd0) begin
        s1_dat0 <= rdata0;
      end
      if (rd1) begin
        s1_dat1 <= rdata1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional second stage: identical hold-on-idle behaviour, strobes delayed
  // in lock step with the data.
  // ---------------------------------------------------------------------------
  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_vld0;
      logic                  s2_vld1;
      logic                  s2_col;
      logic [DATA_WIDTH-1:0] s2_dat0;
      logic [DATA_WIDTH-1:0] s2_dat1;

      always_ff @(posedge clk0) begin
        if (rst0) begin
          s2_vld0 <= 1'b0;
          s2_vld1 <= 1'b0;
          s2_col  <= 1'b0;
          s2_dat0 <= '0;
          s2_dat1 <= '0;
        end else begin
          s2_vld0 <= s1_vld0;
          s2_vld1 <= s1_vld1;
          s2_col  <= s1_col;
          if (s1_vld0) begin
            s2_dat0 <= s1_dat0;
          end
          if (s1_vld1) begin
            s2_dat1 <= s1_dat1;
          end
        end
      end

      assign dout0       = s2_dat0;
      assign dout0_valid = s2_vld0;
      assign dout1       = s2_dat1;
      assign dout1_valid = s2_vld1;
      assign collision   = s2_col;
    end else begin : g_lat1
      assign dout0       = s1_dat0;
      assign dout0_valid = s1_vld0;
      assign dout1       = s1_dat1;
      assign dout1_valid = s1_vld1;
      assign collision   = s1_col;
    end
  endgenerate

endmodule
